// File: rtl/uart_rx_sipo.sv
// UART receiver: oversampled start validation, LSB-first shift-in, parity/stop checks,
// single-cycle delivery strobe with error flags held until the next word.
module uart_rx_sipo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_TYP = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 os_tick,
  input  logic                 data_rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 active_flag
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] HALF_CNT = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] FULL_CNT = OSW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY_TYP != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 armed;
  logic [OSW-1:0]       os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 ferr_acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= data_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_bit     <= 1'b0;
      ferr_acc    <= 1'b0;
      data_out    <= '0;
      valid_flag  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      active_flag <= 1'b0;
    end else begin
      valid_flag <= 1'b0;
      case (state)
        // armed only after the line is seen high, so a break or a reset mid-frame cannot start a frame
        IDLE: begin
          active_flag <= 1'b0;
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state       <= START;
            os_cnt      <= '0;
            armed       <= 1'b0;
            active_flag <= 1'b1;
          end
        end
        START: if (os_tick) begin
          if (os_cnt == HALF_CNT) begin
            if (!rx_s) begin
              state    <= DATA;
              os_cnt   <= '0;
              bit_cnt  <= '0;
              ferr_acc <= 1'b0;
            end else begin
              state       <= IDLE;
              active_flag <= 1'b0;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        DATA: if (os_tick) begin
          if (os_cnt == FULL_CNT) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            os_cnt    <= '0;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        PARITY: if (os_tick) begin
          if (os_cnt == FULL_CNT) begin
            par_bit <= rx_s;
            os_cnt  <= '0;
            bit_cnt <= '0;
            state   <= STOP;
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        STOP: if (os_tick) begin
          if (os_cnt == FULL_CNT) begin
            os_cnt <= '0;
            // deliver at mid-stop so a following start edge is not missed
            if (bit_cnt == LAST_STOP) begin
              data_out    <= shift_reg;
              frame_err   <= ferr_acc | ~rx_s;
              parity_err  <= (PARITY_EN != 0) && (par_bit != ((^shift_reg) ^ PAR_ODD));
              valid_flag  <= 1'b1;
              active_flag <= 1'b0;
              state       <= IDLE;
            end else begin
              ferr_acc <= ferr_acc | ~rx_s;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          active_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo at default framing (8E1, 16x), os_tick every 4 clocks.
module tb_uart_rx_sipo;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       os_tick;
  logic       data_rx;
  logic [7:0] data_out;
  logic       valid_flag;
  logic       parity_err;
  logic       frame_err;
  logic       active_flag;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;
  rec_t rq[$];

  uart_rx_sipo #(
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_TYP(0), .STOP_BITS(1), .OVERSAMPLE(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .os_tick(os_tick), .data_rx(data_rx),
    .data_out(data_out), .valid_flag(valid_flag), .parity_err(parity_err),
    .frame_err(frame_err), .active_flag(active_flag)
  );

  always #5 clock = ~clock;

  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clock);
      #1 os_tick = 1'b1;
      @(posedge clock);
      #1 os_tick = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (valid_flag === 1'b1) rq.push_back('{data_out, parity_err, frame_err});
  end

  task automatic drive_bit(input logic v, input int n);
    data_rx = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_rest(input logic [7:0] d, input logic par, input logic stp, input int bc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
    drive_bit(par, bc);
    drive_bit(stp, bc);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int bc);
    drive_bit(1'b0, bc);
    send_rest(d, par, stp, bc);
  endtask

  task automatic test_reset;
    data_rx = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got %h want 00", data_out); end
    n_cmp++; if (valid_flag !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_flag); end
    n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b%b want 00", parity_err, frame_err); end
    n_cmp++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", active_flag); end
    reset_n = 1'b1;
    drive_bit(1'b1, 20);
  endtask

  task automatic test_basic;
    rq.delete();
    data_rx = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_cmp++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL start_latency_early got %b want 0", active_flag); end
    @(posedge clock); #1;
    n_cmp++; if (active_flag !== 1'b1) begin n_fail++; $display("FAIL start_latency got %b want 1", active_flag); end
    repeat (61) @(posedge clock);
    #1;
    send_rest(8'hA5, 1'b0, 1'b1, 64);
    drive_bit(1'b1, 64);
    n_cmp++; if (rq.size() !== 1) begin n_fail++; $display("FAIL basic_count got %0d want 1", rq.size()); end
    if (rq.size() >= 1) begin
      n_cmp++; if (rq[0].d !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h want a5", rq[0].d); end
      n_cmp++; if ({rq[0].pe, rq[0].fe} !== 2'b00) begin n_fail++; $display("FAIL basic_errs got %b%b want 00", rq[0].pe, rq[0].fe); end
    end
    n_cmp++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL basic_active_after got %b want 0", active_flag); end
  endtask

  task automatic test_parity;
    rq.delete();
    send_frame(8'h3C, 1'b1, 1'b1, 64);
    drive_bit(1'b1, 64);
    n_cmp++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_bad_flag got %b want 1", parity_err); end
    n_cmp++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL parity_bad_data got %h want 3c", data_out); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL parity_bad_ferr got %b want 0", frame_err); end
    send_frame(8'h3C, 1'b0, 1'b1, 64);
    drive_bit(1'b1, 64);
    n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_good_flag got %b want 0", parity_err); end
    n_cmp++; if (rq.size() !== 2) begin n_fail++; $display("FAIL parity_count got %0d want 2", rq.size()); end
  endtask

  task automatic test_frame_err;
    rq.delete();
    send_frame(8'hFF, 1'b0, 1'b0, 64);
    drive_bit(1'b0, 192);
    n_cmp++; if (rq.size() !== 1) begin n_fail++; $display("FAIL break_count got %0d want 1", rq.size()); end
    drive_bit(1'b1, 128);
    send_frame(8'h12, 1'b0, 1'b1, 64);
    drive_bit(1'b1, 64);
    n_cmp++; if (rq.size() !== 2) begin n_fail++; $display("FAIL ferr_count got %0d want 2", rq.size()); end
    if (rq.size() >= 2) begin
      n_cmp++; if ({rq[0].d, rq[0].pe, rq[0].fe} !== {8'hFF, 2'b01}) begin n_fail++; $display("FAIL ferr_first got %h %b%b want ff 01", rq[0].d, rq[0].pe, rq[0].fe); end
      n_cmp++; if ({rq[1].d, rq[1].pe, rq[1].fe} !== {8'h12, 2'b00}) begin n_fail++; $display("FAIL ferr_second got %h %b%b want 12 00", rq[1].d, rq[1].pe, rq[1].fe); end
    end
  endtask

  task automatic test_glitch;
    logic seen;
    rq.delete();
    seen = 1'b0;
    data_rx = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (active_flag === 1'b1) seen = 1'b1;
    end
    data_rx = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (active_flag === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL glitch_active_pulse got %b want 1", seen); end
    n_cmp++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL glitch_active_end got %b want 0", active_flag); end
    n_cmp++; if (rq.size() !== 0) begin n_fail++; $display("FAIL glitch_valid got %0d want 0", rq.size()); end
    n_cmp++; if (data_out !== 8'h12) begin n_fail++; $display("FAIL glitch_data got %h want 12", data_out); end
  endtask

  task automatic test_back_to_back(input int bc);
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h01; exp_d[1] = 8'h80; exp_d[2] = 8'h55;
    rq.delete();
    send_frame(8'h01, 1'b1, 1'b1, bc);
    send_frame(8'h80, 1'b1, 1'b1, bc);
    send_frame(8'h55, 1'b0, 1'b1, bc);
    drive_bit(1'b1, 128);
    n_cmp++; if (rq.size() !== 3) begin n_fail++; $display("FAIL b2b_count_%0d got %0d want 3", bc, rq.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < rq.size()) begin
        n_cmp++;
        if ({rq[i].d, rq[i].pe, rq[i].fe} !== {exp_d[i], 2'b00}) begin
          n_fail++;
          $display("FAIL b2b_word%0d_%0d got %h %b%b want %h 00", i, bc, rq[i].d, rq[i].pe, rq[i].fe, exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'hF1;
    rq.delete();
    drive_bit(1'b0, 64);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 64);
    drive_bit(d[4], 32);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h want 00", data_out); end
    n_cmp++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL midrst_active got %b want 0", active_flag); end
    n_cmp++; if ({valid_flag, parity_err, frame_err} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got %b%b%b want 000", valid_flag, parity_err, frame_err); end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    drive_bit(d[4], 29);
    for (int i = 5; i < 8; i++) drive_bit(d[i], 64);
    drive_bit(1'b1, 64);
    drive_bit(1'b1, 64);
    drive_bit(1'b1, 64);
    send_frame(8'hC3, 1'b0, 1'b1, 64);
    drive_bit(1'b1, 64);
    n_cmp++; if (rq.size() !== 1) begin n_fail++; $display("FAIL midrst_count got %0d want 1", rq.size()); end
    if (rq.size() >= 1) begin
      n_cmp++; if ({rq[0].d, rq[0].pe, rq[0].fe} !== {8'hC3, 2'b00}) begin n_fail++; $display("FAIL midrst_word got %h %b%b want c3 00", rq[0].d, rq[0].pe, rq[0].fe); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    data_rx = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back(64);
    test_back_to_back(66);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
